mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit for the Lapido datapath. It takes the two register-file read operands (A, B) and a destination address, computes one result bit per cycle, and drives a one-cycle write-back (enable, address, data) straight into the register file's write port. It sits between register-file read and register-file write, beside the single-cycle ALU, and holds the pipeline via `busy`.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the mul_div_unit iterative multiply/divide slice.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or restoring-division step
// on the combined 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Multiply: product high half in acc[2W-1:W], remaining multiplier bits shift out of acc[0].
  assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

  // Divide: partial remainder in the high half, dividend/quotient bits in the low half.
  assign trial = acc_i[2*WIDTH-1:WIDTH-1];
  assign fits  = (trial >= {1'b0, opnd_i});
  assign diff  = trial[WIDTH-1:0] - opnd_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      acc_o = fits ? {diff, acc_i[WIDTH-2:0], 1'b1}
                   : {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with register-file write-back, one result bit per cycle.
// Define MULDIV_SIGNED_EN for two's-complement operands and results.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]      result,
  output logic                  div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  op_e                     op_q;
  logic [REG_ADDR_W-1:0]   dest_q;
  logic [WIDTH-1:0]        opnd_q;
  logic [2*WIDTH-1:0]      acc_q;
  logic                    dbz_q;
  logic                    busy_q, wr_en_q, div_by_zero_q;
  logic [WIDTH-1:0]        result_q;
  logic [REG_ADDR_W-1:0]   wr_addr_q;

  logic [2*WIDTH-1:0]      acc_d;
  logic [WIDTH-1:0]        result_d;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic [2*WIDTH-1:0]      prod;
  logic [WIDTH-1:0]        quot, rem;
  logic                    start_is_div;

  assign start_is_div = op[1];

`ifdef MULDIV_SIGNED_EN
  logic neg_q, rem_neg_q;
  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q == OP_DIV || op_q == OP_REM),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  // Result of the final iteration, sign-corrected as it is captured into DONE.
  always_comb begin
    prod = acc_d;
    quot = acc_d[WIDTH-1:0];
    rem  = acc_d[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -acc_d;
      quot = -acc_d[WIDTH-1:0];
    end
    if (rem_neg_q) rem = -acc_d[2*WIDTH-1:WIDTH];
`endif
    if (dbz_q) quot = '1;
    case (op_q)
      OP_MUL:  result_d = prod[WIDTH-1:0];
      OP_MULH: result_d = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  result_d = quot;
      default: result_d = rem;
    endcase
  end

  // NOTE: state is written with non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: every register, including the datapath, is cleared so a mid-operation reset leaves nothing stale.
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_MUL;
      dest_q        <= '0;
      opnd_q        <= '0;
      acc_q         <= '0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
      result_q      <= '0;
      wr_addr_q     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
`endif
    end else begin
      wr_en_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CALC;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            op_q    <= op_e'(op);
            dest_q  <= dest;
            dbz_q   <= start_is_div && (op_b == '0);
            acc_q   <= {{WIDTH{1'b0}}, start_is_div ? a_mag : b_mag};
            opnd_q  <= start_is_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            rem_neg_q <= op_a[WIDTH-1];
`endif
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q       <= ST_DONE;
            wr_en_q       <= 1'b1;
            div_by_zero_q <= dbz_q;
            result_q      <= result_d;
            wr_addr_q     <= dest_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign result      = result_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases from the unit's contract plus
// randomized operations checked against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int AW = 3;

  logic          clock, reset, start;
  logic [1:0]    op;
  logic [W-1:0]  op_a, op_b;
  logic [AW-1:0] dest;
  logic          busy, wr_en, div_by_zero;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  result;

  logic [W-1:0]  rf [8];
  int            total = 0;
  int            bad   = 0;

  mul_div_unit #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .dest        (dest),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: writes on the falling edge.
  always @(negedge clock) if (wr_en) rf[wr_addr] <= result;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    longint unsigned sa, sb, p, q, r;
    sa = {32'b0, a};
    sb = {32'b0, b};
`endif
    p = sa * sb;
    q = (b == 0) ? 0 : sa / sb;
    r = (b == 0) ? 0 : sa % sb;
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? '1 : q[W-1:0];
      default: return (b == 0) ? a : r[W-1:0];
    endcase
  endfunction

  // Issue one operation and follow it to write-back; poke_at >= 0 pulses a
  // conflicting start after that many cycles of CALC.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] d,
                        input logic [W-1:0] exp, input int poke_at);
    int busy_n, wr_n, wr_at, dbz_n, guard;
    logic [W-1:0]  res_seen;
    logic [AW-1:0] addr_seen;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check({tag, ":idle_before_start"}, busy, 0);
    op = o; op_a = a; op_b = b; dest = d; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    busy_n = 0; wr_n = 0; wr_at = -1; dbz_n = 0;
    res_seen = '0; addr_seen = '0;
    for (int e = 0; e <= W + 1; e++) begin
      if (e > 0) @(negedge clock);
      if (busy) busy_n++;
      if (div_by_zero) dbz_n++;
      if (wr_en) begin
        wr_n++;
        wr_at     = e;
        res_seen  = result;
        addr_seen = wr_addr;
      end
      if (e == poke_at) begin
        start = 1'b1; op = ~o; op_a = ~a; op_b = b + 5; dest = ~d;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, ":busy_cycles"}, busy_n, W + 1);
    check({tag, ":wr_en_pulses"}, wr_n, 1);
    check({tag, ":wr_en_edge"}, wr_at, W);
    check({tag, ":result"}, res_seen, exp);
    check({tag, ":wr_addr"}, addr_seen, d);
    check({tag, ":div_by_zero"}, dbz_n, (o[1] && b == 0) ? 1 : 0);
    check({tag, ":result_held"}, result, exp);
    check({tag, ":rf_write"}, rf[d], exp);
  endtask

  initial begin
    logic [1:0]    ro;
    logic [W-1:0]  ra, rb;
    logic [AW-1:0] rd;
    int            wr_seen;

    reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; dest = '0;
    repeat (2) @(negedge clock);
    check("reset:busy", busy, 0);
    check("reset:wr_en", wr_en, 0);
    check("reset:result", result, 0);
    check("reset:wr_addr", wr_addr, 0);
    check("reset:div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 3'd3, 32'd42, -1);
    run_op("mul_ones", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h00000001, -1);
`ifdef MULDIV_SIGNED_EN
    run_op("mulh_ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000000, -1);
`else
    run_op("mulh_ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFE, -1);
`endif
    run_op("div_100_7", 2'b10, 32'd100, 32'd7, 3'd4, 32'd14, -1);
    run_op("rem_100_7", 2'b11, 32'd100, 32'd7, 3'd5, 32'd2, -1);
    run_op("div_5_0", 2'b10, 32'd5, 32'd0, 3'd6, 32'hFFFFFFFF, -1);
    run_op("rem_5_0", 2'b11, 32'd5, 32'd0, 3'd7, 32'd5, -1);
`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 3'd1, 32'hFFFFFFFD, -1);
    run_op("rem_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 3'd2, 32'hFFFFFFFF, -1);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 3'd3, 32'h80000000, -1);
    run_op("rem_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h00000000, -1);
`endif
    run_op("start_in_calc", 2'b00, 32'd1234, 32'd5678, 3'd2, 32'd7006652, 5);

    // Reset ten cycles into CALC: busy drops at once and the operation never writes back.
    op = 2'b10; op_a = 32'd1000; op_b = 32'd3; dest = 3'd5; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset:busy", busy, 0);
    check("midreset:wr_en", wr_en, 0);
    check("midreset:result", result, 0);
    check("midreset:wr_addr", wr_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (wr_en) wr_seen++;
    end
    check("midreset:no_writeback", wr_seen, 0);
    check("midreset:busy_after", busy, 0);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      rd = AW'($urandom_range(0, 7));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rd, ref_result(ro, ra, rb), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
